// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the SEQ Y86-64 core: one stage per state,
// data-memory req/ack handshake with timeout, Y86 status tracking, perf counters.
module seq_stage_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       stat_q, stat_d;
    logic [3:0]       icode_q, icode_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic             mem_class;

    // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
    assign mem_class = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= '0;
            timer_q <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            timer_q <= timer_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        timer_d = '0;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        if (state_q != S_IDLE && state_q != S_HALT)
            cyc_d = cyc_q + CNT_W'(1);
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (icode > 4'hB) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else if (icode == 4'h0) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                // ack on the final timeout cycle still completes the access
                if (!mem_class) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ack) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                ins_d   = ins_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            S_HALT:    state_d = S_HALT;
        endcase
    end

    always_comb begin
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        memory_en    = 1'b0;
        writeback_en = 1'b0;
        pc_en        = 1'b0;
        mem_req      = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_FETCH:     fetch_en = 1'b1;
            S_DECODE:    decode_en = 1'b1;
            S_EXECUTE:   execute_en = 1'b1;
            S_MEMORY: begin
                memory_en = 1'b1;
                mem_req   = mem_class;
            end
            S_WRITEBACK: writeback_en = 1'b1;
            S_PCUPD:     pc_en = 1'b1;
            S_HALT:      halted = 1'b1;
            default: ;
        endcase
        stat        = stat_q;
        cycle_count = cyc_q;
        instr_count = ins_q;
    end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: expected stage/req vectors are queued
// as each instruction is issued and popped once per cycle against the outputs.
module tb_seq_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, imem_error, dmem_error, mem_ack;
    logic [3:0]  icode;
    logic        mem_req, fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] cycle_count, instr_count;

    int checks = 0;
    int errors = 0;

    // {fetch, decode, execute, memory, writeback, pc, mem_req}
    localparam logic [6:0] VF  = 7'b1000000;
    localparam logic [6:0] VD  = 7'b0100000;
    localparam logic [6:0] VE  = 7'b0010000;
    localparam logic [6:0] VM  = 7'b0001000;
    localparam logic [6:0] VMR = 7'b0001001;
    localparam logic [6:0] VW  = 7'b0000100;
    localparam logic [6:0] VP  = 7'b0000010;
    localparam logic [6:0] VZ  = 7'b0000000;

    logic [6:0] exp_q[$];
    logic [6:0] exp_v;

    seq_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode),
        .imem_error(imem_error), .dmem_error(dmem_error), .mem_ack(mem_ack),
        .mem_req(mem_req), .fetch_en(fetch_en), .decode_en(decode_en),
        .execute_en(execute_en), .memory_en(memory_en), .writeback_en(writeback_en),
        .pc_en(pc_en), .stat(stat), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] outs();
        return {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en, mem_req};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; icode = 4'h0;
        imem_error = 1'b0; dmem_error = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Reset, pulse start; on return the DUT is in FETCH with icode driven.
    task automatic start_core(input logic [3:0] ic);
        do_reset();
        icode = ic;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== VZ || stat !== 3'd1 || halted !== 1'b0 ||
            cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL reset: outs=%b stat=%0d halted=%b cyc=%0d ins=%0d, want outs=%b stat=1 halted=0 cyc=0 ins=0",
                     outs(), stat, halted, cycle_count, instr_count, VZ);
        end
        // start is only taken from IDLE when asserted
        tick(); tick();
        checks++;
        if (outs() !== VZ) begin
            errors++;
            $display("FAIL idle_hold: outs=%b want %b", outs(), VZ);
        end
    endtask

    task automatic test_opq();
        start_core(4'h6);
        exp_q = '{VF, VD, VE, VM, VW, VP};
        for (int i = 0; i < 6; i++) begin
            exp_v = exp_q.pop_front();
            mem_ack = (i == 3);  // stray ack, no request outstanding
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL opq_stage%0d: outs=%b want %b", i, outs(), exp_v);
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (instr_count !== 32'd1 || cycle_count !== 32'd6 || outs() !== VF) begin
            errors++;
            $display("FAIL opq_counts: ins=%0d cyc=%0d outs=%b, want ins=1 cyc=6 outs=%b",
                     instr_count, cycle_count, outs(), VF);
        end
        // follow with halt instruction
        icode = 4'h0;
        tick();
        checks++;
        if (stat !== 3'd2 || halted !== 1'b1 || outs() !== VZ || cycle_count !== 32'd7) begin
            errors++;
            $display("FAIL opq_then_halt: stat=%0d halted=%b outs=%b cyc=%0d, want stat=2 halted=1 outs=%b cyc=7",
                     stat, halted, outs(), cycle_count, VZ);
        end
    endtask

    task automatic test_mem_ack();
        start_core(4'h5);
        exp_q = '{VF, VD, VE, VMR, VMR, VMR, VW, VP};
        for (int i = 0; i < 8; i++) begin
            exp_v = exp_q.pop_front();
            mem_ack = (i == 5);
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL memack_stage%0d: outs=%b want %b", i, outs(), exp_v);
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (instr_count !== 32'd1 || cycle_count !== 32'd8 || stat !== 3'd1) begin
            errors++;
            $display("FAIL memack_counts: ins=%0d cyc=%0d stat=%0d, want ins=1 cyc=8 stat=1",
                     instr_count, cycle_count, stat);
        end
    endtask

    task automatic test_timeout();
        start_core(4'h5);
        exp_q = '{VF, VD, VE};
        for (int i = 0; i < 16; i++) exp_q.push_back(VMR);
        for (int i = 0; i < 19; i++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL timeout_stage%0d: outs=%b want %b", i, outs(), exp_v);
            end
            tick();
        end
        checks++;
        if (stat !== 3'd3 || halted !== 1'b1 || outs() !== VZ || cycle_count !== 32'd19) begin
            errors++;
            $display("FAIL timeout_halt: stat=%0d halted=%b outs=%b cyc=%0d, want stat=3 halted=1 outs=%b cyc=19",
                     stat, halted, outs(), cycle_count, VZ);
        end
        start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        checks++;
        if (stat !== 3'd3 || halted !== 1'b1 || outs() !== VZ || cycle_count !== 32'd19) begin
            errors++;
            $display("FAIL halt_sticky: stat=%0d halted=%b outs=%b cyc=%0d, want stat=3 halted=1 outs=%b cyc=19",
                     stat, halted, outs(), cycle_count, VZ);
        end
    endtask

    task automatic test_ack_on_timeout();
        start_core(4'h9);
        exp_q = '{VF, VD, VE};
        for (int i = 0; i < 16; i++) exp_q.push_back(VMR);
        exp_q.push_back(VW);
        exp_q.push_back(VP);
        for (int i = 0; i < 21; i++) begin
            exp_v = exp_q.pop_front();
            mem_ack = (i == 18);
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL lastack_stage%0d: outs=%b want %b", i, outs(), exp_v);
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (stat !== 3'd1 || instr_count !== 32'd1 || cycle_count !== 32'd21) begin
            errors++;
            $display("FAIL lastack_counts: stat=%0d ins=%0d cyc=%0d, want stat=1 ins=1 cyc=21",
                     stat, instr_count, cycle_count);
        end
    endtask

    task automatic test_fetch_faults();
        logic [3:0] ic_tab [4] = '{4'h0, 4'hC, 4'hC, 4'hF};
        logic       ie_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] st_tab [4] = '{3'd2, 3'd4, 3'd3, 3'd4};
        for (int k = 0; k < 4; k++) begin
            start_core(ic_tab[k]);
            imem_error = ie_tab[k];
            tick();
            imem_error = 1'b0;
            checks++;
            if (stat !== st_tab[k] || halted !== 1'b1 || outs() !== VZ ||
                instr_count !== 32'd0 || cycle_count !== 32'd1) begin
                errors++;
                $display("FAIL fetch_fault%0d: stat=%0d halted=%b outs=%b ins=%0d cyc=%0d, want stat=%0d halted=1 ins=0 cyc=1",
                         k, stat, halted, outs(), instr_count, cycle_count, st_tab[k]);
            end
        end
        // 4'hB is the highest valid icode
        start_core(4'hB);
        tick();
        checks++;
        if (outs() !== VD || stat !== 3'd1) begin
            errors++;
            $display("FAIL icode_b_valid: outs=%b stat=%0d, want outs=%b stat=1", outs(), stat, VD);
        end
    endtask

    task automatic test_dmem_error();
        start_core(4'h6);
        for (int i = 0; i < 6; i++) tick();
        icode = 4'hA;
        exp_q = '{VF, VD, VE, VMR};
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
            mem_ack    = (i == 3);
            dmem_error = (i == 3);
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL dmem_stage%0d: outs=%b want %b", i, outs(), exp_v);
            end
            tick();
        end
        mem_ack = 1'b0; dmem_error = 1'b0;
        checks++;
        if (stat !== 3'd3 || halted !== 1'b1 || instr_count !== 32'd1 || outs() !== VZ) begin
            errors++;
            $display("FAIL dmem_halt: stat=%0d halted=%b ins=%0d outs=%b, want stat=3 halted=1 ins=1 outs=%b",
                     stat, halted, instr_count, outs(), VZ);
        end
    endtask

    task automatic test_reset_mid_mem();
        start_core(4'h8);
        tick(); tick(); tick();
        checks++;
        if (outs() !== VMR) begin
            errors++;
            $display("FAIL midmem_setup: outs=%b want %b", outs(), VMR);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (outs() !== VZ || stat !== 3'd1 || halted !== 1'b0 ||
            cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL midmem_reset: outs=%b stat=%0d halted=%b cyc=%0d ins=%0d, want outs=%b stat=1 halted=0 cyc=0 ins=0",
                     outs(), stat, halted, cycle_count, instr_count, VZ);
        end
        // latched icode cleared: an OPq must not assert mem_req after restart
        icode = 4'h6; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (outs() !== VM) begin
            errors++;
            $display("FAIL midmem_restart: outs=%b want %b", outs(), VM);
        end
    endtask

    initial begin
        test_reset();
        test_opq();
        test_mem_ack();
        test_timeout();
        test_ack_on_timeout();
        test_fetch_faults();
        test_dmem_error();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
